score_display_ctrl: RTL
=======================

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit is held on the display, legal 2..2^20.
REQ-002 Parameter WIN_LIMIT, default 7: score that ends a game, legal 1..99 decimal.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 win_p1  input  1  player-1 round win, level, synchronized upstream.
REQ-006 win_p2  input  1  player-2 round win, level, synchronized upstream.
REQ-007 clear  input  1  synchronous new-game request.
REQ-008 bcd  output  4  digit code to the seven-segment decoder; 0..9 = digit, 4'hF = blank.
REQ-009 digit_sel  output  4  active-low digit enable, exactly one bit low at all times.
REQ-010 game_over  output  1  high once either score reaches WIN_LIMIT.
REQ-011 winner  output  2  2'b01 = P1, 2'b10 = P2, 2'b00 = none.

Function
REQ-012 Scores SHALL be held as two BCD digits per player (tens, ones), range 00..99.
REQ-013 A win SHALL be a rising edge: input high this cycle, registered copy low.
REQ-014 On a P1 edge with no P2 edge, no clear, game_over low: P1 score SHALL increment by 1 at that clock edge; same for P2.
REQ-015 BCD increment: ones 9 -> 0 with tens+1; score 99 SHALL saturate at 99.
REQ-016 Simultaneous P1 and P2 edges in one cycle SHALL be a tie: neither score changes.
REQ-017 While game_over is high, all win edges SHALL be ignored.
REQ-018 At the edge where a score becomes equal to WIN_LIMIT, game_over SHALL rise and winner SHALL be set, both on that same clock edge as the score update.
REQ-019 clear SHALL set both scores to 00, game_over to 0, winner to 00 on the next edge, take priority over any coincident win edge, and SHALL NOT disturb the scan counter or digit index.
REQ-020 Edge-detect registers SHALL keep updating during clear and game_over, so a win held high across clear is not counted after clear drops.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on the wrap cycle the digit index SHALL advance 0->1->2->3->0.
REQ-022 Digit map: idx0 digit_sel=4'b1110 P2 ones; idx1 4'b1101 P2 tens; idx2 4'b1011 P1 ones; idx3 4'b0111 P1 tens.
REQ-023 bcd and digit_sel SHALL be registered and change on the same edge (no ghosting).
REQ-024 A tens digit of 0 SHALL be output as bcd=4'hF (leading-zero blank); ones digits SHALL always show 0..9.
REQ-025 bcd SHALL reflect the score value current at the edge it is loaded; a score change mid-slot SHALL appear on the next load of that digit, at most one cycle late on the digit currently shown.

Reset
REQ-026 rst SHALL override clear and wins; on the reset edge: scores 00, edge registers 0, scan counter 0, digit index 0, digit_sel=4'b1110, bcd=4'h0, game_over=0, winner=2'b00.
REQ-027 Reset asserted mid-scan or mid-game SHALL produce the REQ-026 state on the next edge with no partial update.

Verification
REQ-028 rst 1 cycle, SCAN_DIV=4 -> digit_sel 1110,1101,1011,0111,1110 each held 4 cycles; bcd 0,F,0,F.
REQ-029 Three P1 pulses, two P2 pulses -> P1=03, P2=02; idx2 bcd=3, idx0 bcd=2, tens slots bcd=F.
REQ-030 win_p1 held high 20 cycles -> P1 increments exactly once.
REQ-031 win_p1 and win_p2 rise same cycle -> both scores unchanged.
REQ-032 WIN_LIMIT=7, seven P2 pulses -> game_over=1, winner=10 on 7th edge; further P1/P2 pulses change nothing; clear -> 00/00, game_over=0, scan phase unaffected.
REQ-033 WIN_LIMIT=99, nine then one more P1 pulses -> P1=10 (tens=1, ones=0 shown); reach 99 -> game_over=1.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Two-player BCD scoreboard with game-over detection and a
// 4-digit multiplexed seven-segment scan (P1 tens..P2 ones).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   win_p1, win_p2      round-win levels (edge-detected here)
//   clear               new-game request (scores, game_over, winner)
//   bcd                 digit code, 0..9 or 4'hF = blank
//   digit_sel           active-low digit enable
//   game_over, winner   end-of-game flag, 01 = P1, 10 = P2
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned WIN_LIMIT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win_p1,
  input  logic       win_p2,
  input  logic       clear,
  output logic [3:0] bcd,
  output logic [3:0] digit_sel,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [7:0] LIM = {4'(WIN_LIMIT / 10), 4'(WIN_LIMIT % 10)};

  logic [7:0]    p1_q, p1_d;
  logic [7:0]    p2_q, p2_d;
  logic          r1_q, r2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [3:0]    sel_q, sel_d;
  logic          go_q, go_d;
  logic [1:0]    win_q, win_d;
  logic          e1, e2;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  // Leading-zero blanking for tens digits.
  function automatic logic [3:0] tens(input logic [3:0] t);
    return (t == 4'd0) ? 4'hF : t;
  endfunction

  assign e1 = win_p1 & ~r1_q;
  assign e2 = win_p2 & ~r2_q;

  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    go_d  = go_q;
    win_d = win_q;
    if (clear) begin
      p1_d  = 8'h00;
      p2_d  = 8'h00;
      go_d  = 1'b0;
      win_d = 2'b00;
    end else if (!go_q && (e1 ^ e2)) begin
      if (e1) begin
        p1_d = bcd_inc(p1_q);
        if (p1_d == LIM) begin
          go_d  = 1'b1;
          win_d = 2'b01;
        end
      end else begin
        p2_d = bcd_inc(p2_q);
        if (p2_d == LIM) begin
          go_d  = 1'b1;
          win_d = 2'b10;
        end
      end
    end
  end

  // Display is reloaded every cycle from the settled score, so a
  // score change shows up one cycle after it lands.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    sel_d = 4'b1110;
    bcd_d = p2_q[3:0];
    unique case (idx_d)
      2'd0: begin
        sel_d = 4'b1110;
        bcd_d = p2_q[3:0];
      end
      2'd1: begin
        sel_d = 4'b1101;
        bcd_d = tens(p2_q[7:4]);
      end
      2'd2: begin
        sel_d = 4'b1011;
        bcd_d = p1_q[3:0];
      end
      2'd3: begin
        sel_d = 4'b0111;
        bcd_d = tens(p1_q[7:4]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q  <= 8'h00;
      p2_q  <= 8'h00;
      r1_q  <= 1'b0;
      r2_q  <= 1'b0;
      cnt_q <= '0;
      idx_q <= 2'd0;
      bcd_q <= 4'h0;
      sel_q <= 4'b1110;
      go_q  <= 1'b0;
      win_q <= 2'b00;
    end else begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      r1_q  <= win_p1;
      r2_q  <= win_p2;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      bcd_q <= bcd_d;
      sel_q <= sel_d;
      go_q  <= go_d;
      win_q <= win_d;
    end
  end

  assign bcd       = bcd_q;
  assign digit_sel = sel_q;
  assign game_over = go_q;
  assign winner    = win_q;

endmodule
